rsa_modexp_ctrl: RTL and testbench

Sequencer that computes C = M^E mod N for 256-bit operands using the team's Montgomery blocks. It drives the pre-processing engine once and then time-shares a single Montgomery-multiply (MA) engine between the multiply and square steps of right-to-left binary exponentiation. It sits between the RSA top level and the two engines, owns all operand registers, and presents a start/done interface upward.

---
 rtl/rsa_modexp_ctrl.sv | 146 ++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left binary modular exponentiation sequencer for 256-bit RSA.
// Drives the pre-processing engine once, then time-shares one Montgomery multiplier.
module rsa_modexp_ctrl #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] M,
    input  logic [W-1:0] E,
    input  logic [W-1:0] N,
    output logic [W-1:0] eng_N,
    output logic         pp_start,
    output logic [W-1:0] pp_M,
    input  logic [W:0]   pp_S,
    input  logic         pp_ready,
    output logic         ma_start,
    output logic [W-1:0] ma_A,
    output logic [W-1:0] ma_B,
    input  logic [W:0]   ma_V,
    input  logic         ma_ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] C,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        IDLE, PRE_ISSUE, PRE_WAIT, MUL_ISSUE, MUL_WAIT, SQR_ISSUE, SQR_WAIT, FIN
    } state_t;

    state_t       state;
    logic [W-1:0] m, t, e, nl, ml;
    logic [7:0]   k;

    // Engines guarantee results below N, so the top result bit carries nothing.
    logic unused_hi;
    assign unused_hi = pp_S[W] ^ ma_V[W];

    assign eng_N     = nl;
    assign pp_M      = ml;
    assign dbg_state = state;

    // Handshakes: start is a one-cycle request honoured only in IDLE; busy/done are levels.
    // Engine start pulses are high exactly during the ISSUE state; engine ready is a level
    // looked at only in the WAIT states, so a ready left over from the previous op is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            m        <= '0;
            t        <= '0;
            e        <= '0;
            nl       <= '0;
            ml       <= '0;
            k        <= '0;
            pp_start <= 1'b0;
            ma_start <= 1'b0;
            ma_A     <= '0;
            ma_B     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            C        <= '0;
        end else begin
            pp_start <= 1'b0;
            ma_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ml       <= M;
                        nl       <= N;
                        e        <= E;
                        m        <= W'(1);
                        k        <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        pp_start <= 1'b1;
                        state    <= PRE_ISSUE;
                    end
                end
                PRE_ISSUE: state <= PRE_WAIT;
                PRE_WAIT: begin
                    if (pp_ready) begin
                        t <= pp_S[W-1:0];
                        if (e[0]) begin
                            ma_start <= 1'b1;
                            ma_A     <= m;
                            ma_B     <= pp_S[W-1:0];
                            state    <= MUL_ISSUE;
                        end else if (k == 8'd255) begin
                            state <= FIN;
                        end else begin
                            ma_start <= 1'b1;
                            ma_A     <= pp_S[W-1:0];
                            ma_B     <= pp_S[W-1:0];
                            state    <= SQR_ISSUE;
                        end
                    end
                end
                MUL_ISSUE: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (ma_ready) begin
                        m <= ma_V[W-1:0];
                        if (k == 8'd255) begin
                            state <= FIN;
                        end else begin
                            ma_start <= 1'b1;
                            ma_A     <= t;
                            ma_B     <= t;
                            state    <= SQR_ISSUE;
                        end
                    end
                end
                SQR_ISSUE: state <= SQR_WAIT;
                SQR_WAIT: begin
                    if (ma_ready) begin
                        t <= ma_V[W-1:0];
                        e <= e >> 1;
                        k <= k + 8'd1;
                        // e[1] is the exponent bit that becomes e[0] after this shift.
                        if (e[1]) begin
                            ma_start <= 1'b1;
                            ma_A     <= m;
                            ma_B     <= ma_V[W-1:0];
                            state    <= MUL_ISSUE;
                        end else if (k == 8'd254) begin
                            state <= FIN;
                        end else begin
                            ma_start <= 1'b1;
                            ma_A     <= ma_V[W-1:0];
                            ma_B     <= ma_V[W-1:0];
                            state    <= SQR_ISSUE;
                        end
                    end
                end
                FIN: begin
                    C     <= m;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: behavioural pre-processing and Montgomery engines,
// results checked against plain square-and-multiply modular exponentiation.
module tb_rsa_modexp_ctrl;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] M = '0, E = '0, N = '0;
    logic [W-1:0] eng_N, pp_M, ma_A, ma_B, C;
    logic [W:0]   pp_S, ma_V;
    logic         pp_start, pp_ready, ma_start, ma_ready, busy, done;
    logic [2:0]   dbg_state;

    int total = 0;
    int bad = 0;
    int wait_cycles = 256;
    int pp_starts = 0;
    int ma_starts = 0;
    int pp_cnt, ma_cnt;

    rsa_modexp_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .M(M), .E(E), .N(N),
        .eng_N(eng_N), .pp_start(pp_start), .pp_M(pp_M), .pp_S(pp_S), .pp_ready(pp_ready),
        .ma_start(ma_start), .ma_A(ma_A), .ma_B(ma_B), .ma_V(ma_V), .ma_ready(ma_ready),
        .busy(busy), .done(done), .C(C), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] n);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, n};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] modexp_ref(input logic [W-1:0] mm, input logic [W-1:0] ee,
                                                input logic [W-1:0] nn);
        logic [W-1:0] r, b;
        r = W'(1);
        b = mm;
        for (int i = 0; i < W; i++) begin
            if (ee[i]) r = mulmod(r, b, nn);
            b = mulmod(b, b, nn);
        end
        return r;
    endfunction

    function automatic logic [W:0] pre_f(input logic [W-1:0] x, input logic [W-1:0] n);
        logic [2*W-1:0] w;
        w = {x, {W{1'b0}}} % {{W{1'b0}}, n};
        return w[W:0];
    endfunction

    function automatic logic [W:0] mont_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
        logic [2*W+1:0] x;
        x = (2*W+2)'(a) * (2*W+2)'(b);
        for (int i = 0; i < W; i++) begin
            if (x[0]) x = x + (2*W+2)'(n);
            x = x >> 1;
        end
        if (x >= (2*W+2)'(n)) x = x - (2*W+2)'(n);
        return x[W:0];
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    // Engines: ready drops on the edge that sees start, then rises so that the
    // controller spends exactly wait_cycles cycles in its WAIT state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_ready <= 1'b0; pp_cnt <= 0; pp_S <= '0;
        end else if (pp_start) begin
            pp_ready <= 1'b0; pp_cnt <= wait_cycles - 1;
        end else if (pp_cnt != 0) begin
            pp_cnt <= pp_cnt - 1;
            if (pp_cnt == 1) begin
                pp_ready <= 1'b1;
                pp_S     <= pre_f(pp_M, eng_N);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_ready <= 1'b0; ma_cnt <= 0; ma_V <= '0;
        end else if (ma_start) begin
            ma_ready <= 1'b0; ma_cnt <= wait_cycles - 1;
        end else if (ma_cnt != 0) begin
            ma_cnt <= ma_cnt - 1;
            if (ma_cnt == 1) begin
                ma_ready <= 1'b1;
                ma_V     <= mont_f(ma_A, ma_B, eng_N);
            end
        end
    end

    always @(posedge clk) begin
        if (pp_start) pp_starts <= pp_starts + 1;
        if (ma_start) ma_starts <= ma_starts + 1;
    end

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_now(input logic [W-1:0] mm, input logic [W-1:0] ee, input logic [W-1:0] nn);
        start = 1'b1; M = mm; E = ee; N = nn;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle index in which done is first seen (cycle 0 ends with the accepting edge).
    task automatic wait_done(output int cyc, output bit busy_ok);
        int limit;
        limit = (wait_cycles + 1) * 520 + 20;
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < limit) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] mm, input logic [W-1:0] ee,
                                 input logic [W-1:0] nn, input bit back_to_back);
        int cyc, pp0, ma0, ops;
        bit busy_ok;
        pp0 = pp_starts;
        ma0 = ma_starts;
        ops = 256 + $countones(ee);
        if (!back_to_back) @(negedge clk);
        start_now(mm, ee, nn);
        if (back_to_back) begin
            chk({tag, "_done_clr"}, (W+1)'(done), (W+1)'(0));
            chk({tag, "_busy_set"}, (W+1)'(busy), (W+1)'(1));
        end
        wait_done(cyc, busy_ok);
        chk({tag, "_timeout"}, (W+1)'(done), (W+1)'(1));
        chk({tag, "_C"}, (W+1)'(C), (W+1)'(modexp_ref(mm, ee, nn)));
        chk({tag, "_cycle"}, (W+1)'(cyc), (W+1)'(1 + (wait_cycles + 1) * ops + 1));
        chk({tag, "_busy_held"}, (W+1)'(busy_ok), (W+1)'(1));
        chk({tag, "_busy_low"}, (W+1)'(busy), (W+1)'(0));
        chk({tag, "_pp_starts"}, (W+1)'(pp_starts - pp0), (W+1)'(1));
        chk({tag, "_ma_starts"}, (W+1)'(ma_starts - ma0), (W+1)'(255 + $countones(ee)));
    endtask

    initial begin
        logic [W-1:0] ra, re, rn, rm2;
        int cyc;
        bit busy_ok;

        // Reset values
        #12;
        chk("rst_busy", (W+1)'(busy), (W+1)'(0));
        chk("rst_done", (W+1)'(done), (W+1)'(0));
        chk("rst_C", (W+1)'(C), (W+1)'(0));
        chk("rst_pp_start", (W+1)'(pp_start), (W+1)'(0));
        chk("rst_ma_start", (W+1)'(ma_start), (W+1)'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Full engine latency: 2^5 mod 13 = 6
        wait_cycles = 256;
        run_and_check("m2e5", W'(2), W'(5), W'(13), 1'b0);

        // Shortened engine latency for the remaining runs
        wait_cycles = 2;
        run_and_check("e0", W'(7), W'(0), W'(11), 1'b0);
        run_and_check("e1", W'(123456789), W'(1), W'(1000000007), 1'b0);
        run_and_check("eall", W'(3), '1, (W'(1) << 255) + W'(95), 1'b0);
        chk("eall_C_zero_check", (W+1)'(C == '0), (W+1)'(0));

        for (int i = 0; i < 4; i++) begin
            rn = rand256() | (W'(1) << 255) | W'(1);
            ra = rand256() % rn;
            re = rand256();
            run_and_check("rand", ra, re, rn, 1'b0);
        end

        // A second start during a run is ignored
        rn = rand256() | (W'(1) << 255) | W'(1);
        ra = rand256() % rn;
        re = rand256();
        rm2 = ra ^ W'(64'h5a5a_0f0f_1234_8765);
        @(negedge clk);
        start_now(ra, re, rn);
        repeat (300) @(negedge clk);
        start_now(rm2, rand256(), rn);
        chk("ign_pp_M", (W+1)'(pp_M), (W+1)'(ra));
        chk("ign_busy", (W+1)'(busy), (W+1)'(1));
        wait_done(cyc, busy_ok);
        chk("ign_timeout", (W+1)'(done), (W+1)'(1));
        chk("ign_C", (W+1)'(C), (W+1)'(modexp_ref(ra, re, rn)));
        chk("ign_busy_held", (W+1)'(busy_ok), (W+1)'(1));

        // Start on the cycle done is high
        rn = rand256() | (W'(1) << 255) | W'(1);
        ra = rand256() % rn;
        re = rand256();
        run_and_check("b2b", ra, re, rn, 1'b1);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start_now(W'(2), W'(5), W'(13));
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", (W+1)'(busy), (W+1)'(0));
        chk("midrst_done", (W+1)'(done), (W+1)'(0));
        chk("midrst_C", (W+1)'(C), (W+1)'(0));
        chk("midrst_ma_start", (W+1)'(ma_start), (W+1)'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("after_rst", W'(2), W'(5), W'(13), 1'b0);
        chk("after_rst_C6", (W+1)'(C), (W+1)'(6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
